dr_ctrl: RTL and testbench

DR_CTRL -- requirements
Module: dr_ctrl

---
 rtl/dr_pkg.sv | 24 ++
 rtl/dr_sel_gen.sv | 21 ++
 rtl/dr_ctrl.sv | 117 +++++++++++
 tb/tb_dr_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared encodings for the data-reordering controller: FSM states,
// schedule mode codes and datapath latency.
package dr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_PAT  = 2'b10;
  localparam logic [1:0] MODE_ROT  = 2'b11;

  // Datapath register stages between an accepted word and out_valid.
  localparam int unsigned DR_LAT = 1;

  // Beat counter width, sized for up to 16 beats per frame.
  localparam int unsigned BEAT_W = 4;

endpackage

// File: rtl/dr_sel_gen.sv
// Combinational select schedule: maps (mode, beat index) to {s1,s0}.
module dr_sel_gen
  import dr_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [BEAT_W-1:0] beat,
  output logic [1:0]        sel
);

  // Decode the schedule for the requested beat; sel is {s1,s0}.
  always_comb begin
    sel = 2'b00;
    case (mode)
      MODE_PASS: sel = 2'b00;
      MODE_SWAP: sel = 2'b11;
      MODE_PAT:  sel = {(~beat[2]) | beat[1], (~beat[3]) | beat[0]};
      MODE_ROT:  sel = beat[1:0];
    endcase
  end

endmodule

// File: rtl/dr_ctrl.sv
// Frame sequencer for the reordering datapath: accepts frame_len+1 beats,
// drives the registered select lines per beat and tracks the one-deep
// output stage of the datapath.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; mode/frame_len captured on the start edge
// LOAD  | one cycle: dr_clear pulse, beat_cnt zeroed, beat-0 selects loaded
// RUN   | accepting beats while the output stage can take one
// DRAIN | last beat accepted; waiting for its output to be taken
// DONE  | one cycle: done pulse, then back to IDLE
module dr_ctrl
  import dr_pkg::*;
#(
  parameter int N    = 8,
  parameter int MAXB = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [BEAT_W-1:0] frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s0,
  output logic              s1,
  output logic              dr_clear,
  output logic              busy,
  output logic              done,
  output logic [BEAT_W-1:0] beat_cnt
);

  // The controller is built for a 16-beat counter and a single-stage datapath;
  // N only travels with the datapath and needs no logic here.
  if (N < 1 || MAXB != (1 << BEAT_W) || DR_LAT != 1) begin : g_param_check
  end

  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic [BEAT_W-1:0] flen_q;
  logic [BEAT_W-1:0] sel_idx;
  logic [1:0]        sel_nx;
  logic [1:0]        sel_q;
  logic              xfer;
  logic              last_beat;

  assign in_ready  = (state == ST_RUN) & (~out_valid | out_ready);
  assign xfer      = in_valid & in_ready;
  assign last_beat = (beat_cnt == flen_q);

  // LOAD prepares beat 0; afterwards the selects look one beat ahead.
  assign sel_idx = (state == ST_LOAD) ? '0 : beat_cnt + 1'b1;

  dr_sel_gen u_sel_gen (
    .mode (mode_q),
    .beat (sel_idx),
    .sel  (sel_nx)
  );

  assign s0 = sel_q[0];
  assign s1 = sel_q[1];

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx = state;
    busy     = (state != ST_IDLE);
    dr_clear = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        dr_clear = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN:   if (xfer && last_beat) state_nx = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready) state_nx = ST_DONE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Frame configuration, beat counter, select register and output stage.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mode_q    <= '0;
      flen_q    <= '0;
      beat_cnt  <= '0;
      sel_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        mode_q <= mode;
        flen_q <= frame_len;
      end
      if (state == ST_LOAD) begin
        beat_cnt <= '0;
        sel_q    <= sel_nx;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
        sel_q    <= sel_nx;
      end
      out_valid <= xfer | (out_valid & ~out_ready);
    end
  end

endmodule

// File: tb/tb_dr_ctrl.sv
// Directed bench for dr_ctrl: reset values, each schedule mode, output
// back-pressure, mid-frame clear, ignored start pulses and frame-length edges.
module tb_dr_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [1:0] mode;
  logic [3:0] frame_len;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       s0;
  logic       s1;
  logic       dr_clear;
  logic       busy;
  logic       done;
  logic [3:0] beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived pattern schedule, index k = 0..15, value {s1,s0}.
  logic [1:0] pat_exp [16] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11,
                               2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};

  dr_ctrl #(.N(8), .MAXB(16)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .mode      (mode),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s0        (s0),
    .s1        (s1),
    .dr_clear  (dr_clear),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sched(input logic [1:0] m, input int k);
    logic [3:0] kb;
    kb = 4'(k);
    case (m)
      2'b00:   return 2'b00;
      2'b01:   return 2'b11;
      2'b10:   return pat_exp[kb];
      default: return kb[1:0];
    endcase
  endfunction

  // One complete frame with in_valid held high. stall_k >= 0 drops out_ready
  // for stall_len cycles right after beat stall_k is accepted; poke keeps
  // start high for the whole frame after the accepted request.
  task automatic run_frame(input logic [1:0] m, input logic [3:0] fl, input bit poke,
                           input int stall_k, input int stall_len, input string nm);
    int k, n_out, n_done, done_c, stall_left;
    logic [1:0] sel_frz;
    k = 0; n_out = 0; n_done = 0; done_c = -1; stall_left = 0; sel_frz = 2'b00;
    mode = m; frame_len = fl; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    cyc();
    chk({nm, "_load_dr_clear"}, 32'(dr_clear), 1);
    chk({nm, "_load_busy"}, 32'(busy), 1);
    chk({nm, "_load_in_ready"}, 32'(in_ready), 0);
    start = poke;
    mode = ~m;
    frame_len = ~fl;
    for (int c = 0; c < 120 && n_done == 0; c++) begin
      cyc();
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (c == 0) chk({nm, "_dr_clear_1cyc"}, 32'(dr_clear), 0);
      if (!out_ready) begin
        chk({nm, "_stall_in_ready"}, 32'(in_ready), 0);
        chk({nm, "_stall_out_valid"}, 32'(out_valid), 1);
        chk({nm, "_stall_sel"}, 32'({s1, s0}), 32'(sel_frz));
        chk({nm, "_stall_beat"}, 32'(beat_cnt), k);
      end
      if (in_valid && in_ready) begin
        chk({nm, "_beat_cnt"}, 32'(beat_cnt), k);
        chk({nm, "_sel"}, 32'({s1, s0}), 32'(sched(m, k)));
        k++;
        if (k - 1 == stall_k) begin
          stall_left = stall_len;
          sel_frz = sched(m, k);
        end
      end
      if (out_valid && out_ready) n_out++;
      if (done) begin
        n_done++;
        done_c = c;
      end
    end
    start = 1'b0;
    chk({nm, "_xfers"}, k, 32'(fl) + 1);
    chk({nm, "_outputs"}, n_out, 32'(fl) + 1);
    chk({nm, "_dones"}, n_done, 1);
    chk({nm, "_done_cycle"}, done_c, 32'(fl) + 2 + stall_len);
    cyc();
    chk({nm, "_idle_busy"}, 32'(busy), 0);
    chk({nm, "_idle_done"}, 32'(done), 0);
    chk({nm, "_end_beat_cnt"}, 32'(beat_cnt), 32'(4'(fl + 4'd1)));
    cyc();
    chk({nm, "_no_2nd_done"}, 32'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit5;
    clear = 1'b1; start = 1'b0; mode = 2'b00; frame_len = 4'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'({s1, s0}), 0);
    chk("rst_dr_clear", 32'(dr_clear), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
    clear = 1'b0;

    // Swap, 4 beats, start honoured on the first edge after reset.
    run_frame(2'b01, 4'd3, 1'b0, -1, 0, "swap");

    // in_valid outside RUN is ignored.
    in_valid = 1'b1;
    cyc();
    chk("idle_in_ready", 32'(in_ready), 0);
    cyc();
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_beat_cnt", 32'(beat_cnt), 4);

    // Pattern over a full 16-beat frame; beat_cnt wraps only at the end.
    run_frame(2'b10, 4'd15, 1'b0, -1, 0, "pat");

    // Rotate with output back-pressure after beat 2.
    run_frame(2'b11, 4'd7, 1'b0, 2, 4, "rot");

    // start held through RUN/DRAIN/DONE must not launch a second frame.
    run_frame(2'b01, 4'd5, 1'b1, -1, 0, "poke");

    // Single-beat frame.
    run_frame(2'b11, 4'd0, 1'b0, -1, 0, "one");

    // Clear in the middle of a frame at beat 5.
    mode = 2'b10; frame_len = 4'd15; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    hit5 = 1'b0;
    for (int c = 0; c < 40 && !hit5; c++) begin
      cyc();
      #1;
      if (beat_cnt == 4'd5) hit5 = 1'b1;
    end
    chk("clr_reach_beat5", 32'(beat_cnt), 5);
    clear = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 0);
    chk("clr_out_valid", 32'(out_valid), 0);
    chk("clr_sel", 32'({s1, s0}), 0);
    chk("clr_dr_clear", 32'(dr_clear), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_beat_cnt", 32'(beat_cnt), 0);
    cyc();
    chk("clr_hold_done", 32'(done), 0);
    clear = 1'b0;
    cyc();
    chk("clr_after_done", 32'(done), 0);
    chk("clr_after_busy", 32'(busy), 0);

    // Clean pass frame after the clear.
    run_frame(2'b00, 4'd4, 1'b0, -1, 0, "post_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
